seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Holds a 32-bit hex value (8 nibbles) and a per-digit enable mask.
- Cycles through the digits: drives the 3-bit digit select and 4-bit nibble into the existing segment/anode decoder, and drives active-low anodes directly.
- Inserts an anti-ghosting blank gap between digits. Host writes are double-buffered and committed only at frame boundaries.

---
 rtl/seg_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display with
// a blank gap between digits and frame-boundary commit of host writes.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits.
module seg_scan_ctrl #(
  parameter int DIV = 100000,
  parameter int GAP = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_mask,
  output logic        pending,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic [7:0]  an,
  output logic        frame_start
);

  if ((GAP < 1) || (GAP >= DIV)) begin : g_param_check
    $error("seg_scan_ctrl: parameters must satisfy 1 <= GAP < DIV");
  end

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - GAP - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [2:0]     idx_r;
  logic [2:0]     idx_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_s;
  logic           commit_s;
  logic [31:0]    active_data_r;
  logic [31:0]    data_s;
  logic [7:0]     active_mask_r;
  logic [7:0]     mask_s;
  logic [31:0]    buf_data_r;
  logic [7:0]     buf_mask_r;
  logic           lit_s;
  logic [7:0]     an_s;
  logic [2:0]     sel_s;
  logic [3:0]     num_s;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit idx is a leading zero when it and every more-significant nibble are 0.
  function automatic logic lead_zero(input logic [31:0] data, input logic [2:0] idx);
    logic [31:0] upper;
    upper = data >> {idx, 2'b00};
    return (idx != 3'd0) && (upper == 32'd0);
  endfunction
`endif

  // Next-state, commit decision and next output values.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    cnt_s    = cnt_r;
    commit_s = 1'b0;
    case (state_r)
      ST_OFF: begin
        if (en) begin
          state_s  = ST_SHOW;
          idx_s    = 3'd0;
          cnt_s    = '0;
          commit_s = 1'b1;
        end else begin
          state_s  = ST_OFF;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          state_s = ST_OFF;
          idx_s   = 3'd0;
          cnt_s   = '0;
        end else if (cnt_r == SHOW_LAST) begin
          state_s = ST_GAP;
          cnt_s   = '0;
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
      end
      ST_GAP: begin
        if (!en) begin
          state_s = ST_OFF;
          idx_s   = 3'd0;
          cnt_s   = '0;
        end else if (cnt_r == GAP_LAST) begin
          state_s  = ST_SHOW;
          cnt_s    = '0;
          idx_s    = idx_r + 3'd1;
          commit_s = (idx_r == 3'd7);
        end else begin
          cnt_s    = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_OFF;
        idx_s   = 3'd0;
        cnt_s   = '0;
      end
    endcase

    // The commit edge already shows the newly committed value.
    if (commit_s && pending) begin
      data_s = buf_data_r;
      mask_s = buf_mask_r;
    end else begin
      data_s = active_data_r;
      mask_s = active_mask_r;
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    lit_s = mask_s[idx_s] & ~lead_zero(data_s, idx_s);
`else
    lit_s = mask_s[idx_s];
`endif

    an_s  = 8'hFF;
    sel_s = 3'd0;
    num_s = 4'd0;
    case (state_s)
      ST_OFF: begin
        an_s  = 8'hFF;
        sel_s = 3'd0;
        num_s = 4'd0;
      end
      ST_SHOW: begin
        sel_s = idx_s;
        num_s = data_s[{idx_s, 2'b00} +: 4];
        if (lit_s) begin
          an_s = ~(8'b0000_0001 << idx_s);
        end else begin
          an_s = 8'hFF;
        end
      end
      ST_GAP: begin
        an_s  = 8'hFF;
        sel_s = sel;
        num_s = num;
      end
      default: begin
        an_s  = 8'hFF;
        sel_s = 3'd0;
        num_s = 4'd0;
      end
    endcase
  end

  // State, display buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_OFF;
      idx_r         <= 3'd0;
      cnt_r         <= '0;
      active_data_r <= 32'd0;
      active_mask_r <= 8'hFF;
      buf_data_r    <= 32'd0;
      buf_mask_r    <= 8'd0;
      pending       <= 1'b0;
      num           <= 4'd0;
      sel           <= 3'd0;
      an            <= 8'hFF;
      frame_start   <= 1'b0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      cnt_r         <= cnt_s;
      active_data_r <= data_s;
      active_mask_r <= mask_s;
      num           <= num_s;
      sel           <= sel_s;
      an            <= an_s;
      frame_start   <= commit_s;
      // A write on a commit edge lands after the old buffer is taken.
      if (wr_en) begin
        buf_data_r <= wr_data;
        buf_mask_r <= wr_mask;
        pending    <= 1'b1;
      end else if (commit_s) begin
        pending    <= 1'b0;
      end else begin
        pending    <= pending;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIV=10, GAP=2): vector table,
// slot-arithmetic scoreboard every cycle, and directed corner sequences.
module tb_seg_scan_ctrl;

  localparam int TDIV = 10;
  localparam int TGAP = 2;

  logic        clk;
  logic        reset;
  logic        en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_mask;
  logic        pending;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic        frame_start;

  seg_scan_ctrl #(.DIV(TDIV), .GAP(TGAP)) dut (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_data(wr_data),
    .wr_mask(wr_mask), .pending(pending), .num(num), .sel(sel), .an(an),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] an;
    logic [2:0] sel;
    logic [3:0] num;
    logic       fs;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // drive values applied on the next tick
  logic        d_reset = 1'b1;
  logic        d_en    = 1'b0;
  logic        d_wr    = 1'b0;
  logic [31:0] d_data  = 32'd0;
  logic [7:0]  d_mask  = 8'hFF;

  // reference model state (time since enable, committed and buffered values)
  logic        m_on   = 1'b0;
  int          m_t    = 0;
  logic [31:0] m_ad   = 32'd0;
  logic [7:0]  m_am   = 8'hFF;
  logic [31:0] m_buf  = 32'd0;
  logic [7:0]  m_bufm = 8'd0;
  logic        m_pend = 1'b0;

  logic [16:0] sb_q[$];
  int cyc = 0;
  int fs_cyc = 0;
  int fs_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  task automatic model_step();
    logic       boundary;
    logic       lit;
    int         digit;
    logic [7:0] e_an;
    logic [2:0] e_sel;
    logic [3:0] e_num;
    boundary = 1'b0;
    e_an = 8'hFF; e_sel = 3'd0; e_num = 4'd0;
    if (d_reset) begin
      m_on = 1'b0; m_t = 0; m_ad = 32'd0; m_am = 8'hFF;
      m_buf = 32'd0; m_bufm = 8'd0; m_pend = 1'b0;
    end else begin
      if (!d_en) begin
        m_on = 1'b0;
      end else begin
        if (!m_on) begin
          m_on = 1'b1;
          m_t = 0;
        end else begin
          m_t++;
        end
        boundary = ((m_t % (8 * TDIV)) == 0);
      end
      if (boundary && m_pend) begin
        m_ad = m_buf;
        m_am = m_bufm;
      end
      if (d_wr) begin
        m_buf = d_data; m_bufm = d_mask; m_pend = 1'b1;
      end else if (boundary) begin
        m_pend = 1'b0;
      end
      if (m_on) begin
        digit = (m_t / TDIV) % 8;
        e_sel = 3'(digit);
        e_num = 4'((m_ad >> (4 * digit)) & 32'hF);
        lit = m_am[digit] && ((m_t % TDIV) < (TDIV - TGAP));
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (digit != 0 && (m_ad >> (4 * digit)) == 32'd0) lit = 1'b0;
`endif
        e_an = lit ? ~(8'h01 << digit) : 8'hFF;
      end
    end
    sb_q.push_back({m_pend, e_an, e_sel, e_num, boundary});
  endtask

  task automatic tick();
    logic [16:0] exp;
    reset = d_reset; en = d_en; wr_en = d_wr; wr_data = d_data; wr_mask = d_mask;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (frame_start === 1'b1) begin
      fs_gap = cyc - fs_cyc;
      fs_cyc = cyc;
    end
    exp = sb_q.pop_front();
    check("scoreboard", {15'd0, pending, an, sel, num, frame_start}, {15'd0, exp});
    d_wr = 1'b0;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_t < target && guard < 2000) begin
      tick();
      guard++;
    end
  endtask

  task automatic write(input logic [31:0] data, input logic [7:0] mask);
    d_wr = 1'b1; d_data = data; d_mask = mask;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [13];
    logic [3:0] nib6 [8];
    logic [7:0] exp_an;

    vecs[0] = '{rst: 1'b1, en: 1'b0, an: 8'hFF, sel: 3'd0, num: 4'd0, fs: 1'b0};
    vecs[1] = '{rst: 1'b0, en: 1'b0, an: 8'hFF, sel: 3'd0, num: 4'd0, fs: 1'b0};
    for (int i = 2; i < 10; i++)
      vecs[i] = '{rst: 1'b0, en: 1'b1, an: 8'hFE, sel: 3'd0, num: 4'd0, fs: (i == 2)};
    vecs[10] = '{rst: 1'b0, en: 1'b1, an: 8'hFF, sel: 3'd0, num: 4'd0, fs: 1'b0};
    vecs[11] = '{rst: 1'b0, en: 1'b1, an: 8'hFF, sel: 3'd0, num: 4'd0, fs: 1'b0};
    vecs[12] = '{rst: 1'b0, en: 1'b1, an: 8'hFD, sel: 3'd1, num: 4'd0, fs: 1'b0};

    reset = 1'b1; en = 1'b0; wr_en = 1'b0; wr_data = 32'd0; wr_mask = 8'hFF;

    // reset, idle, enable and first slot
    for (int i = 0; i < 13; i++) begin
      d_reset = vecs[i].rst;
      d_en = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), {20'd0, an, sel, frame_start},
            {20'd0, vecs[i].an, vecs[i].sel, vecs[i].fs});
      if (i == 0) check("reset_pending", {31'd0, pending}, 32'd0);
    end

    // full first frame
    run_to(70);
    check("t70_an", {24'd0, an}, 32'h7F);
    check("t70_sel", {29'd0, sel}, 32'd7);
    run_to(79);
    check("t79_an", {24'd0, an}, 32'hFF);
    run_to(80);
    check("t80_fs", {31'd0, frame_start}, 32'd1);
    check("t80_an", {24'd0, an}, 32'hFE);
    check("fs_period1", fs_gap, 32'd80);

    // write during digit 3, commit at wrap
    run_to(110);
    write(32'h12345678, 8'hFF);
    check("wr_pending", {31'd0, pending}, 32'd1);
    check("wr_num_old", {28'd0, num}, 32'd0);
    run_to(159);
    check("pre_commit_pending", {31'd0, pending}, 32'd1);
    check("pre_commit_num", {28'd0, num}, 32'd0);
    run_to(160);
    check("commit_fs", {31'd0, frame_start}, 32'd1);
    check("commit_pending", {31'd0, pending}, 32'd0);
    check("commit_num0", {28'd0, num}, 32'd8);
    check("fs_period2", fs_gap, 32'd80);
    run_to(230);
    check("digit7_sel", {29'd0, sel}, 32'd7);
    check("digit7_num", {28'd0, num}, 32'd1);
    check("digit7_an", {24'd0, an}, 32'h7F);

    // mask 0x0F: upper digits dark but still scanned
    write(32'h12345678, 8'h0F);
    for (int d = 0; d < 8; d++) begin
      run_to(240 + 10 * d);
      exp_an = (d < 4) ? ~(8'h01 << d) : 8'hFF;
      check($sformatf("mask_sel%0d", d), {29'd0, sel}, d);
      check($sformatf("mask_an%0d", d), {24'd0, an}, {24'd0, exp_an});
    end

    // disable mid-SHOW of digit 3, then re-enable
    run_to(353);
    check("pre_dis_sel", {29'd0, sel}, 32'd3);
    d_en = 1'b0;
    tick();
    check("dis_outs", {17'd0, an, sel, num}, {17'd0, 8'hFF, 3'd0, 4'd0});
    tick();
    tick();
    d_en = 1'b1;
    tick();
    check("reen_fs", {31'd0, frame_start}, 32'd1);
    check("reen_outs", {17'd0, an, sel, num}, {17'd0, 8'hFE, 3'd0, 4'd8});

    // write B on the commit edge of pending A
    run_to(5);
    write(32'h000000A1, 8'hFF);
    run_to(79);
    write(32'h000000B2, 8'hFF);
    check("ab_fs", {31'd0, frame_start}, 32'd1);
    check("ab_pending", {31'd0, pending}, 32'd1);
    check("ab_numA", {28'd0, num}, 32'd1);
    run_to(160);
    check("ab_fs2", {31'd0, frame_start}, 32'd1);
    check("ab_pending2", {31'd0, pending}, 32'd0);
    check("ab_numB", {28'd0, num}, 32'd2);

    // leading-zero data
    run_to(165);
    write(32'h00000A05, 8'hFF);
    nib6 = '{4'h5, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int d = 0; d < 8; d++) begin
      run_to(240 + 10 * d);
      exp_an = ~(8'h01 << d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (d >= 3) exp_an = 8'hFF;
`endif
      check($sformatf("lz_num%0d", d), {28'd0, num}, {28'd0, nib6[d]});
      check($sformatf("lz_an%0d", d), {24'd0, an}, {24'd0, exp_an});
    end

    // reset mid-frame drops a pending write
    run_to(245);
    write(32'h0000FFFF, 8'hFF);
    d_reset = 1'b1;
    tick();
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_outs", {17'd0, an, sel, num}, {17'd0, 8'hFF, 3'd0, 4'd0});
    d_reset = 1'b0;
    tick();
    check("rst_reen_fs", {31'd0, frame_start}, 32'd1);
    check("rst_reen_outs", {17'd0, pending, an, sel, num}, {17'd0, 1'b0, 8'hFE, 3'd0, 4'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
